// File: rtl/barcode_rx_param_if.sv
// Receiver-to-navigation bundle: raw barcode line, decoded ID and status.
// The master side is the receiver, the slave side the consumer.
interface barcode_rx_param_if #(
    parameter int ID_W = 8
);
    logic            BC;
    logic            clr_ID_vld;
    logic            ID_vld;
    logic [ID_W-1:0] ID;
    logic            frm_err;
    logic            ovr;
    logic            busy;

    modport master (
        input  BC,
        input  clr_ID_vld,
        output ID_vld,
        output ID,
        output frm_err,
        output ovr,
        output busy
    );

    modport slave (
        output BC,
        output clr_ID_vld,
        input  ID_vld,
        input  ID,
        input  frm_err,
        input  ovr,
        input  busy
    );
endinterface

// File: rtl/barcode_rx_param.sv
// Self-clocked station-ID barcode receiver; the bit period is learned
// from each frame's start bit.
module barcode_rx_param #(
    parameter int ID_W     = 8,
    parameter int VLD_BITS = 2,
    parameter int CNT_W    = 22,
    parameter int MIN_LOW  = 4
) (
    input logic                clk,
    input logic                rst,
    barcode_rx_param_if.master bus
);
    localparam int BW = $clog2(ID_W + 1);
    localparam logic [ID_W-1:0] VMASK =
        ID_W'(((32'd1 << VLD_BITS) - 32'd1) << (ID_W - VLD_BITS));

    typedef enum logic [2:0] {
        IDLE, CAP, WAIT_FALL, SAMP, DONE
    } state_t;

    state_t st, nxt;

    logic             s1, bc_s, bc_d;
    logic             fall, rise;
    logic [CNT_W-1:0] cnt, ref_len;
    logic [CNT_W+1:0] ref4, cnt_x;
    logic [BW-1:0]    bitcnt;
    logic [ID_W-1:0]  shreg, id_q;
    logic             id_vld_q, frm_err_q, ovr_q, busy_q;
    logic             cnt_max, hit, last, tmo, valid;
    logic             err_set, load;

    // Synchroniser resets to idle-high so reset never fakes a falling edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b1;
            bc_s <= 1'b1;
            bc_d <= 1'b1;
        end else begin
            s1   <= bus.BC;
            bc_s <= s1;
            bc_d <= bc_s;
        end
    end

    assign fall    = !bc_s & bc_d;
    assign rise    = bc_s & !bc_d;
    assign cnt_max = &cnt;
    assign hit     = (cnt == ref_len);
    assign last    = (bitcnt == BW'(ID_W - 1));
    assign ref4    = {ref_len, 2'b00};
    assign cnt_x   = {2'b00, cnt};
    // A saturated counter also ends the wait when 4*ref is out of reach
    assign tmo     = (cnt_x >= ref4) || cnt_max;
    assign valid   = ((shreg & VMASK) == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st     <= IDLE;
            busy_q <= 1'b0;
        end else begin
            st     <= nxt;
            busy_q <= (nxt != IDLE);
        end
    end

    always_comb begin
        nxt = st;
        unique case (st)
            IDLE: begin
                if (fall) nxt = CAP;
            end
            CAP: begin
                if (rise)
                    nxt = (cnt < CNT_W'(MIN_LOW)) ? IDLE : WAIT_FALL;
                else if (cnt_max)
                    nxt = IDLE;
            end
            WAIT_FALL: begin
                if (fall)     nxt = SAMP;
                else if (tmo) nxt = IDLE;
            end
            SAMP: begin
                if (hit) nxt = last ? DONE : WAIT_FALL;
            end
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        err_set = 1'b0;
        load    = 1'b0;
        unique case (st)
            CAP:       err_set = !rise && cnt_max;
            WAIT_FALL: err_set = !fall && tmo;
            DONE: begin
                load    = valid;
                err_set = !valid;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            ref_len   <= '0;
            bitcnt    <= '0;
            shreg     <= '0;
            id_q      <= '0;
            id_vld_q  <= 1'b0;
            frm_err_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            frm_err_q <= err_set;
            // A clear landing with a fresh set is not an overrun
            ovr_q <= load & id_vld_q & ~bus.clr_ID_vld;
            if (load) begin
                id_q     <= shreg;
                id_vld_q <= 1'b1;
            end else if (bus.clr_ID_vld) begin
                id_vld_q <= 1'b0;
            end
            unique case (st)
                IDLE: begin
                    bitcnt <= '0;
                    cnt    <= fall ? CNT_W'(1) : '0;
                end
                CAP: begin
                    if (rise) begin
                        if (cnt >= CNT_W'(MIN_LOW)) ref_len <= cnt;
                        cnt <= '0;
                    end else if (!bc_s && !cnt_max) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_FALL: begin
                    if (fall)          cnt <= CNT_W'(1);
                    else if (!cnt_max) cnt <= cnt + 1'b1;
                end
                SAMP: begin
                    if (hit) begin
                        shreg  <= {shreg[ID_W-2:0], bc_s};
                        bitcnt <= bitcnt + 1'b1;
                        cnt    <= '0;
                    end else if (!cnt_max) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    assign bus.ID      = id_q;
    assign bus.ID_vld  = id_vld_q;
    assign bus.frm_err = frm_err_q;
    assign bus.ovr     = ovr_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_barcode_rx_param.sv
// Directed bench for barcode_rx_param: two 8-bit receivers (VLD_BITS 2 and 0)
// share one line, a 12-bit receiver has its own.
module tb_barcode_rx_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nvec = 0;
    int   nerr = 0;
    bit   sel = 1'b0;
    logic vb, va;
    int   e0 = 0, e1 = 0, e2 = 0, o0 = 0, o1 = 0, o2 = 0;
    int   de, dd, doo;

    always #5 clk = ~clk;

    barcode_rx_param_if #(.ID_W(8))  i0 ();
    barcode_rx_param_if #(.ID_W(8))  i1 ();
    barcode_rx_param_if #(.ID_W(12)) i2 ();

    barcode_rx_param #(.ID_W(8), .VLD_BITS(2)) u0 (
        .clk(clk), .rst(rst), .bus(i0));
    barcode_rx_param #(.ID_W(8), .VLD_BITS(0)) u1 (
        .clk(clk), .rst(rst), .bus(i1));
    barcode_rx_param #(.ID_W(12), .VLD_BITS(0)) u2 (
        .clk(clk), .rst(rst), .bus(i2));

    always @(posedge clk) begin
        if (i0.frm_err) e0++;
        if (i1.frm_err) e1++;
        if (i2.frm_err) e2++;
        if (i0.ovr) o0++;
        if (i1.ovr) o1++;
        if (i2.ovr) o2++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setbc(input logic v);
        if (sel == 1'b0) begin
            i0.BC = v;
            i1.BC = v;
        end else begin
            i2.BC = v;
        end
    endtask

    task automatic hold(input logic v, input int n);
        setbc(v);
        repeat (n) tick();
    endtask

    task automatic send_start();
        hold(1'b0, 20);
        hold(1'b1, 20);
    endtask

    task automatic send_bit(input logic b);
        hold(1'b0, b ? 8 : 32);
        hold(1'b1, b ? 32 : 8);
    endtask

    task automatic clr_all();
        i0.clr_ID_vld = 1'b1;
        i1.clr_ID_vld = 1'b1;
        i2.clr_ID_vld = 1'b1;
        tick();
        i0.clr_ID_vld = 1'b0;
        i1.clr_ID_vld = 1'b0;
        i2.clr_ID_vld = 1'b0;
    endtask

    // The last bit snapshots ID_vld just before and after the update edge,
    // which lands 24 edges after the last falling drive of BC.
    task automatic send_frame(input logic [15:0] val, input int n,
                              input bit do_clr);
        int len;
        send_start();
        for (int i = n - 1; i >= 1; i--) send_bit(val[i]);
        len = val[0] ? 8 : 32;
        for (int t = 0; t < 40; t++) begin
            setbc(t < len ? 1'b0 : 1'b1);
            if (sel == 1'b0) i0.clr_ID_vld = do_clr && (t == 23);
            else             i2.clr_ID_vld = do_clr && (t == 23);
            tick();
            if (t == 22) vb = sel ? i2.ID_vld : i0.ID_vld;
            if (t == 23) va = sel ? i2.ID_vld : i0.ID_vld;
        end
        i0.clr_ID_vld = 1'b0;
        i2.clr_ID_vld = 1'b0;
    endtask

    initial begin
        i0.BC = 1'b1; i1.BC = 1'b1; i2.BC = 1'b1;
        i0.clr_ID_vld = 1'b0;
        i1.clr_ID_vld = 1'b0;
        i2.clr_ID_vld = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_id", i0.ID, 0);
        chk("rst_vld", i0.ID_vld, 0);
        chk("rst_busy", i0.busy, 0);
        chk("rst_err", i0.frm_err, 0);
        chk("rst_ovr", i0.ovr, 0);
        rst = 1'b0;
        tick();
        tick();

        de = e0;
        send_frame(16'h2A, 8, 1'b0);
        chk("nom_vld_before", vb, 0);
        chk("nom_vld_after", va, 1);
        chk("nom_id", i0.ID, 8'h2A);
        chk("nom_err", e0 - de, 0);
        chk("nom_busy", i0.busy, 0);
        chk("nom_id_v0", i1.ID, 8'h2A);

        clr_all();
        chk("clr_vld", i0.ID_vld, 0);
        chk("clr_id", i0.ID, 8'h2A);

        de = e0; dd = o1;
        send_frame(16'hC5, 8, 1'b0);
        chk("vfail_err", e0 - de, 1);
        chk("vfail_id", i0.ID, 8'h2A);
        chk("vfail_vld", i0.ID_vld, 0);
        chk("v0_id", i1.ID, 8'hC5);
        chk("v0_vld", i1.ID_vld, 1);
        chk("v0_ovr", o1 - dd, 0);

        de = e0; dd = o1;
        hold(1'b0, 2);
        hold(1'b1, 10);
        chk("glitch_busy", i0.busy, 0);
        chk("glitch_err", e0 - de, 0);
        send_frame(16'h15, 8, 1'b0);
        chk("glitch_id", i0.ID, 8'h15);
        chk("glitch_vld", i0.ID_vld, 1);
        chk("glitch_v0_ovr", o1 - dd, 1);

        clr_all();
        de = e0;
        hold(1'b0, 20);
        hold(1'b1, 50);
        chk("tmo_busy_mid", i0.busy, 1);
        chk("tmo_err_mid", e0 - de, 0);
        hold(1'b1, 50);
        chk("tmo_err", e0 - de, 1);
        chk("tmo_busy", i0.busy, 0);
        doo = o0;
        send_frame(16'h0F, 8, 1'b0);
        chk("tmo_next_id", i0.ID, 8'h0F);
        chk("tmo_next_vld", i0.ID_vld, 1);
        chk("tmo_next_ovr", o0 - doo, 0);

        clr_all();
        doo = o0;
        send_frame(16'h11, 8, 1'b0);
        chk("ovr_first", o0 - doo, 0);
        send_frame(16'h22, 8, 1'b0);
        chk("ovr_second", o0 - doo, 1);
        chk("ovr_id", i0.ID, 8'h22);

        doo = o0;
        send_frame(16'h11, 8, 1'b1);
        chk("coll_vld_before", vb, 1);
        chk("coll_vld_after", va, 1);
        chk("coll_ovr", o0 - doo, 0);
        chk("coll_id", i0.ID, 8'h11);

        send_start();
        for (int i = 7; i >= 4; i--) send_bit(1'(16'h3C >> i));
        chk("mid_busy", i0.busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_id", i0.ID, 0);
        chk("mid_rst_vld", i0.ID_vld, 0);
        chk("mid_rst_busy", i0.busy, 0);
        chk("mid_rst_err", i0.frm_err, 0);
        tick();
        rst = 1'b0;
        tick();
        de = e0; doo = o0;
        send_frame(16'h3C, 8, 1'b0);
        chk("mid_next_id", i0.ID, 8'h3C);
        chk("mid_next_vld", i0.ID_vld, 1);
        chk("mid_next_err", e0 - de, 0);
        chk("mid_next_ovr", o0 - doo, 0);

        sel = 1'b1;
        de = e2;
        send_frame(16'hABC, 12, 1'b0);
        chk("w12_vld_before", vb, 0);
        chk("w12_vld_after", va, 1);
        chk("w12_id", i2.ID, 12'hABC);
        chk("w12_err", e2 - de, 0);
        chk("w12_ovr", o2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
